// File: rtl/dsc_pkg.sv
// Shared types and length helpers for the deterministic
// stochastic-computing clock-division multiplier.
package dsc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} dsc_state_t;
    typedef enum logic {UNIPOLAR, BIPOLAR} dsc_mode_t;

    // log2 of the full combined stream length, 2^(n*w)
    function automatic int stream_log2(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/dsc_unary_sng.sv
// Per-operand unary stream generator: a wrapping position counter
// compared against the latched operand.
module dsc_unary_sng #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] d,
    output logic         s,
    output logic         wrap
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clr)
                cnt <= '0;
            else if (adv)
                cnt <= cnt + 1'b1;
        end
    end

    assign s    = (cnt < d);
    assign wrap = &cnt;

endmodule

// File: rtl/dsc_clkdiv_mul.sv
// N-input clock-division stochastic multiplier: every combination of
// stream positions is visited once, so the ones-count is exact.
module dsc_clkdiv_mul
    import dsc_pkg::*;
#(
    parameter  int DATA_WIDTH = 5,
    parameter  int NUM_INPUTS = 2,
    localparam int OUT_WIDTH  = stream_log2(NUM_INPUTS, DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
    output logic [OUT_WIDTH-1:0]  bin_data_out,
    output logic                  busy,
    output logic                  done
);

    dsc_state_t state, state_nxt;
    dsc_mode_t  mode_q;

    logic [DATA_WIDTH-1:0] d_q [NUM_INPUTS];
    logic [OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]  out_q;

    logic [NUM_INPUTS-1:0] s;
    logic [NUM_INPUTS-1:0] wrap;
    logic [NUM_INPUTS-1:0] adv;

    logic accept;
    logic run_en;
    logic last;
    logic b;

    assign accept = (state == IDLE) && start && en;
    assign run_en = (state == RUN) && en;
    assign last   = run_en && (&wrap);

    // Operand i steps only when all lower-index counters wrap together
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_sng
        if (i == 0) begin : g_first
            assign adv[i] = (state == RUN);
        end else begin : g_rest
            assign adv[i] = adv[i-1] & wrap[i-1];
        end

        dsc_unary_sng #(
            .W(DATA_WIDTH)
        ) u_sng (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .clr  (accept),
            .adv  (adv[i]),
            .d    (d_q[i]),
            .s    (s[i]),
            .wrap (wrap[i])
        );
    end

    // Bipolar: 1 when the count of zero stream bits is even
    always_comb begin
        b = 1'b0;
        unique case (mode_q)
            UNIPOLAR: b = &s;
            BIPOLAR:  b = ~(^(~s));
            default:  b = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    if (en)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= UNIPOLAR;
            acc    <= '0;
            out_q  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                d_q[i] <= '0;
        end else if (en) begin
            state <= state_nxt;
            if (accept) begin
                mode_q <= dsc_mode_t'(mode);
                acc    <= '0;
                for (int i = 0; i < NUM_INPUTS; i++)
                    d_q[i] <= bin_data_in[i];
            end
            if (run_en)
                acc <= acc + OUT_WIDTH'(b);
            if (last)
                out_q <= acc + OUT_WIDTH'(b);
        end
    end

    assign bin_data_out = out_q;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_dsc_clkdiv_mul.sv
// Directed bench for dsc_clkdiv_mul: a W=5/N=2 instance and a
// W=3/N=3 instance driven from one clock.
module tb_dsc_clkdiv_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic        start5;
    logic        mode5;
    logic [4:0]  d5 [2];
    logic [10:0] out5;
    logic        busy5;
    logic        done5;

    logic        start3;
    logic        mode3;
    logic [2:0]  d3 [3];
    logic [9:0]  out3;
    logic        busy3;
    logic        done3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsc_clkdiv_mul #(
        .DATA_WIDTH(5),
        .NUM_INPUTS(2)
    ) dut5 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start5),
        .mode         (mode5),
        .bin_data_in  (d5),
        .bin_data_out (out5),
        .busy         (busy5),
        .done         (done5)
    );

    dsc_clkdiv_mul #(
        .DATA_WIDTH(3),
        .NUM_INPUTS(3)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start3),
        .mode         (mode3),
        .bin_data_in  (d3),
        .bin_data_out (out3),
        .busy         (busy3),
        .done         (done3)
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run5(input logic [4:0] a, input logic [4:0] c,
                        input logic m, input int exp_out,
                        input int exp_lat, input int prev,
                        input int stall_at, input int stall_len,
                        input string tag);
        int n;
        int busy_cnt;
        d5[0]  = a;
        d5[1]  = c;
        mode5  = m;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk({tag, "_busy0"}, busy5, 1);
        n        = 0;
        busy_cnt = 1;
        while (!done5 && n < 4000) begin
            if (n == stall_at)
                en = 1'b0;
            if (n == stall_at + stall_len)
                en = 1'b1;
            if (n == 300) begin
                chk({tag, "_hold"}, out5, prev);
                start5 = 1'b1;
                d5[0]  = 5'd7;
                d5[1]  = 5'd9;
                mode5  = ~m;
            end
            if (n == 301)
                start5 = 1'b0;
            tick();
            n++;
            if (busy5)
                busy_cnt++;
        end
        en = 1'b1;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_busycnt"}, busy_cnt, exp_lat);
        chk({tag, "_out"}, out5, exp_out);
        tick();
        chk({tag, "_donelow"}, done5, 0);
        chk({tag, "_outheld"}, out5, exp_out);
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] c,
                        input logic [2:0] e, input logic m,
                        input int exp_out, input string tag);
        int n;
        d3[0]  = a;
        d3[1]  = c;
        d3[2]  = e;
        mode3  = m;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 512);
        chk({tag, "_out"}, out3, exp_out);
        tick();
    endtask

    function automatic int bip3(input int a, input int c, input int e);
        int cnt;
        int z;
        cnt = 0;
        for (int p0 = 0; p0 < 8; p0++)
            for (int p1 = 0; p1 < 8; p1++)
                for (int p2 = 0; p2 < 8; p2++) begin
                    z = int'(p0 >= a) + int'(p1 >= c) + int'(p2 >= e);
                    if (z % 2 == 0)
                        cnt++;
                end
        return cnt;
    endfunction

    initial begin
        int ra, rc, re, rm, ex;
        rst    = 1'b1;
        en     = 1'b1;
        start5 = 1'b0;
        mode5  = 1'b0;
        d5[0]  = '0;
        d5[1]  = '0;
        start3 = 1'b0;
        mode3  = 1'b0;
        for (int i = 0; i < 3; i++)
            d3[i] = '0;
        tick();
        tick();
        chk("rst_out", out5, 0);
        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_out3", out3, 0);
        rst = 1'b0;
        tick();

        run5(5'd31, 5'd31, 1'b0, 961, 1024, 0, 99999, 0, "u31");
        run5(5'd16, 5'd16, 1'b1, 512, 1024, 961, 99999, 0, "b16");
        run5(5'd31, 5'd31, 1'b1, 962, 1024, 512, 99999, 0, "b31");
        run5(5'd0, 5'd0, 1'b1, 1024, 1024, 962, 99999, 0, "b0");
        run5(5'd0, 5'd17, 1'b0, 0, 1024, 1024, 99999, 0, "u0");
        run5(5'd1, 5'd1, 1'b0, 1, 1024, 0, 99999, 0, "u1");
        run5(5'd20, 5'd11, 1'b0, 220, 1061, 1, 600, 37, "stall");

        // start with en low must be ignored
        en     = 1'b0;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        en     = 1'b1;
        tick();
        chk("en0_start", busy5, 0);

        // reset mid-run discards the partial result
        d5[0]  = 5'd31;
        d5[1]  = 5'd31;
        mode5  = 1'b0;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        repeat (500) tick();
        chk("pre_rst_busy", busy5, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", out5, 0);
        chk("mid_rst_busy", busy5, 0);
        chk("mid_rst_done", done5, 0);
        tick();
        rst = 1'b0;
        tick();
        run5(5'd3, 5'd5, 1'b0, 15, 1024, 0, 99999, 0, "after_rst");

        run3(3'd7, 3'd5, 3'd2, 1'b0, 70, "n3_u");
        run3(3'd4, 3'd4, 3'd4, 1'b1, 256, "n3_b");
        for (int k = 0; k < 4; k++) begin
            ra = int'($urandom_range(0, 7));
            rc = int'($urandom_range(0, 7));
            re = int'($urandom_range(0, 7));
            rm = int'($urandom_range(0, 1));
            ex = (rm == 1) ? bip3(ra, rc, re) : ra * rc * re;
            run3(3'(ra), 3'(rc), 3'(re), rm[0], ex, "n3_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsc_clkdiv_mul.md
# dsc_clkdiv_mul

Parametrised deterministic stochastic-computing multiplier for the arch-sweep datapath. It replaces the fixed two-input naive multiplier with an N-input clock-division engine. Each binary operand is converted to a unary bitstream, and the streams are advanced so that every combination of stream positions is visited exactly once. The engine then counts the ones of the combined stream, which gives an exact product. Unipolar (AND) and bipolar (XNOR) modes are run-time selectable, and a start/done handshake and an enable stall are provided.

## Interface
- DATA_WIDTH, 5, bits per operand (W); stream length per operand 2^W
- NUM_INPUTS, 2, number of operands (N), ≥ 2
- OUT_WIDTH, NUM_INPUTS*DATA_WIDTH+1, result width; localparam, not overridable
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  global enable; low freezes all state including the FSM, counters and accumulator
- start  input  1  request; sampled only in IDLE with en=1
- mode  input  1  0 = unipolar AND, 1 = bipolar XNOR; latched with operands at start
- bin_data_in  input  [DATA_WIDTH-1:0] x NUM_INPUTS  unpacked operand array; latched at start
- bin_data_out  output  OUT_WIDTH  ones-count of the combined stream; held until the next completion
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE

## Operation
- Reset values: FSM=IDLE; bin_data_out, busy and done are 0; all counters, latched operands and the accumulator are 0.
- FSM states:
  - IDLE: on start & en, latch operands and mode, clear the accumulator and counters, and go to RUN.
  - RUN: stays here for T_LEN = 2^(N·W) enabled cycles, then goes to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Counters (clock division):
  - Each operand i has a W-bit counter cnt_i.
  - cnt_0 increments every enabled RUN cycle.
  - cnt_i increments only when cnt_0 through cnt_(i-1) are all at 2^W−1.
  - All counters wrap modulo 2^W.
- Stream bit: s_i = (cnt_i < d_i), an unsigned compare against the latched operand d_i.
- Combining the streams:
  - Unipolar: b = AND of all s_i.
  - Bipolar: b = XNOR-reduction of all s_i, meaning b is 1 when the number of zero bits is even. For N=2 this is plain XNOR.
- Accumulator: OUT_WIDTH bits, adds b every enabled RUN cycle; it cannot overflow.
  - Maximum count in unipolar mode is (2^W−1)^N.
  - Maximum count in bipolar mode is 2^(N·W).
- Completion: on the last RUN cycle (all counters at their maximum), bin_data_out ← accumulator + b.
- start seen while in RUN or DONE is ignored and not queued.
- Operand or mode changes during RUN have no effect.
- d_i = 0 gives s_i ≡ 0. d_i = 2^W−1 gives s_i = 1 on all but one position.

## Timing
- Start sampled at edge 0: busy is high from edge 0.
- Accumulation takes place at edges 1..T_LEN.
- At edge T_LEN: the result is registered, the state becomes DONE, busy=0 and done=1.
- At edge T_LEN+1: done=0 and the state is IDLE. A new start is accepted at the earliest at edge T_LEN+1.
- Start-to-done latency is exactly T_LEN enabled cycles. Each cycle with en=0 delays done by one cycle, with no change to the result.
- rst asserted at any point, including mid-RUN, immediately returns every output and register to its reset value. The partial result is discarded.
- en=0 in the same cycle as start means start is not accepted.

## Structure
- Package dsc_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} dsc_state_t;
  - typedef enum logic {UNIPOLAR, BIPOLAR} dsc_mode_t;
  - a function for clog2-style length constants.
- Sub-module dsc_unary_sng: per-operand counter and comparator.
  - Inputs: clk, rst, en, clr, adv, d.
  - Outputs: s, wrap, where wrap = (cnt == 2^W−1).
  - Instantiated NUM_INPUTS times with a generate loop.
  - The adv chain is formed from the AND of the lower-index wrap outputs.
- The top level holds the FSM, the combine logic, the accumulator and the output register.

## Test plan
- W=5, N=2, unipolar, d={31,31}, start at edge 0 → done at edge 1024, bin_data_out=961, busy high for 1024 cycles.
- W=5, N=2, bipolar, d={16,16} → 512; d={31,31} → 962; d={0,0} → 1024.
- Unipolar, d={0,17} → 0; then immediately restart with d={1,1} → 1. Check that the previous output is held until the second done.
- en held low for 37 cycles mid-RUN, d={20,11} unipolar → done at edge 1061, result 220. Also: start pulses during RUN are ignored.
- rst asserted at cycle 500 of a run → outputs 0 and state IDLE at once. A new start with d={3,5} then completes to 15 after 1024 cycles.
- W=3, N=3, unipolar, d={7,5,2} → done after 512 cycles, result 70. Also a random sweep comparing against the product (unipolar) or the XNOR reference count (bipolar).
